calc_arbiter: RTL and testbench
===============================

# calc_arbiter

Round-robin scheduler that shares one `calculator` datapath among `NUM_REQ` requesters. Accepts at most one operation per cycle over per-requester valid/ready handshakes and drives the calculator's operand/function inputs from registers. Tracks in-flight operations through the calculator's fixed latency and returns each result on a shared, tagged response bus. Traps divide-by-zero before issue and never presents it to the datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester tag width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: grant, one-hot or zero.
- `req_func` in `NUM_REQ`x2: opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV).
- `req_a`, `req_b` in `NUM_REQ`x8 signed: operands.
- `calc_function_out` out 2: to calculator `function_in`.
- `calc_dat_a_out`, `calc_dat_b_out` out 8 signed: to calculator operands.
- `calc_out_in` in 16 signed: from calculator `out`.
- `rsp_valid` out 1: one-cycle response strobe, no backpressure.
- `rsp_id` out `ID_W`: requester tag.
- `rsp_data` out 16 signed: result.
- `rsp_err` out 1: divide-by-zero trap.

## Operation
- Handshake: transfer on `req_valid[i] & req_ready[i]` at a rising edge. `req_ready` is combinational from `req_valid` and the RR pointer. Requester must hold func/operands stable while valid and not ready.
- Arbitration: grant the first valid requester at or after `rr_ptr`, scanning upward with wrap. On a transfer, `rr_ptr <= grant_idx + 1` (mod `NUM_REQ`). With no valid request, `rr_ptr` holds. At most one grant per cycle.
- Issue: on transfer, register func/a/b into `calc_*_out`. With no transfer, drive func 00 and operands 0.
- Divide-by-zero: func 11 with `b == 0` is accepted normally but issued as func 00 with 0/0 operands. It is tagged `err=1` and its response carries `rsp_data = 0`, `rsp_err = 1`.
- Tracking: 3-stage shift register of {valid, id, err}, advanced every cycle. Stage 3 aligns with `calc_out_in` carrying that operation's result.
- Response: registered from stage 3. `rsp_data = err ? 0 : calc_out_in`.
- Arithmetic: results are defined by the calculator. 8-bit signed operands give a 16-bit signed result. DIV truncates toward zero. No saturation is applied here.
- Responses return in acceptance order. Throughput is 1 op/cycle sustained.
- Reset values:
  - `req_ready` = 0 while `rst` is high.
  - `calc_*_out` = 0, `rr_ptr` = 0.
  - All tracking-stage valids = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0.
- Reset mid-flight: every in-flight operation is dropped and no response is ever produced for it. Calculator output is ignored while tracking valids are 0.

## Timing
- Transfer in cycle t → `calc_*_out` valid in cycle t+1.
- The calculator input register captures at the end of t+1, and its output register at the end of t+2.
- `calc_out_in` is valid in cycle t+3. `rsp_valid` is high in cycle t+4, for exactly one cycle.
- Fixed latency: 4 cycles from accept to response, including the DIV-by-zero case.
- Back-to-back accepts produce back-to-back responses with no bubbles.
- `rst` asserted in cycle r: from cycle r+1 all outputs hold reset values. `req_ready` is also forced low combinationally during r. The first possible accept is the first cycle with `rst` low.

## Structure
- `calc_pkg`:
  - `calc_op_e` enum (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`).
  - `CALC_LAT = 2` (calculator register latency).
  - `OPND_W = 8`, `RES_W = 16`.
  - `ARB_LAT = CALC_LAT + 2`.
- Sub-module `rr_arbiter`: parameterised `NUM_REQ`. Inputs are `req` vector and `advance`; outputs are one-hot `grant` and `grant_idx`. It owns `rr_ptr`.
- The top level holds the issue registers, the tracking shift register and the response register.

## Test plan
- Single op: req1 ADD a=5, b=-3 accepted in cycle 0 → cycle 4 `rsp_valid=1`, `rsp_id=1`, `rsp_data=2`, `rsp_err=0`; no other `rsp_valid`.
- Full contention: all four requesters continuously valid from reset release → grants 0,1,2,3,0,… one per cycle, with responses back-to-back in the same id order.
- Extremes: MUL -128 × -128 → 16384; SUB -128 − 127 → -255; DIV -7 / 2 → -3.
- Divide-by-zero: req2 DIV 7/0 → cycle t+1 calculator sees func 00 with 0/0; cycle t+4 returns `rsp_id=2`, `rsp_data=0`, `rsp_err=1`.
- Fairness: req0 held valid continuously and req2 raised in cycle k → req2 granted no later than cycle k+1, and req0 gets at most one grant in between.
- Reset mid-flight: accept ops in cycles 0 and 1, assert `rst` in cycle 2 → no `rsp_valid` through cycle 10, all outputs 0, and the next grant after release starts scanning from requester 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and latency constants for the calculator arbiter slice.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  localparam int unsigned CALC_LAT = 2;
  localparam int unsigned OPND_W   = 8;
  localparam int unsigned RES_W    = 16;
  localparam int unsigned ARB_LAT  = CALC_LAT + 2;

endpackage

// File: rtl/calc_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  localparam int unsigned   N    = NUM_REQ;
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] scan_idx;
  int unsigned     scan_sum;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      // rr_ptr_q < N, so a single subtraction wraps the scan position
      scan_sum = 32'(rr_ptr_q) + off;
      if (scan_sum >= N) scan_sum = scan_sum - N;
      scan_idx = ID_W'(scan_sum);
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && found) begin
      rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one fixed-latency calculator among NUM_REQ requesters; returns tagged
// results in acceptance order and traps divide-by-zero before issue.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][1:0]         req_func,
  input  logic [NUM_REQ-1:0][OPND_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OPND_W-1:0]  req_b,
  output logic [1:0]                      calc_function_out,
  output logic signed [OPND_W-1:0]        calc_dat_a_out,
  output logic signed [OPND_W-1:0]        calc_dat_b_out,
  input  logic signed [RES_W-1:0]         calc_out_in,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic signed [RES_W-1:0]         rsp_data,
  output logic                            rsp_err
);

  localparam int unsigned TRK_N = ARB_LAT - 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } trk_t;

  logic [NUM_REQ-1:0] arb_req, grant;
  logic [ID_W-1:0]    grant_idx;
  logic               xfer;

  calc_op_e           sel_op;
  logic [OPND_W-1:0]  sel_a, sel_b;
  logic               div_zero;

  calc_op_e           func_q, func_d;
  logic [OPND_W-1:0]  a_q, a_d, b_q, b_d;
  trk_t               trk_in;
  trk_t [TRK_N-1:0]   trk_q, trk_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  // Masking requests during reset keeps req_ready low combinationally.
  assign arb_req   = rst ? '0 : req_valid;
  assign req_ready = grant;
  assign xfer      = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_op   = calc_op_e'(req_func[grant_idx]);
    sel_a    = req_a[grant_idx];
    sel_b    = req_b[grant_idx];
    div_zero = xfer && (sel_op == OP_DIV) && (sel_b == '0);

    func_d = OP_ADD;
    a_d    = '0;
    b_d    = '0;
    if (xfer && !div_zero) begin
      func_d = sel_op;
      a_d    = sel_a;
      b_d    = sel_b;
    end

    trk_in.valid = xfer;
    trk_in.id    = grant_idx;
    trk_in.err   = div_zero;
    trk_d        = {trk_q[TRK_N-2:0], trk_in};

    // Last tracking stage lines up with calc_out_in for the same operation.
    rsp_valid_d = trk_q[TRK_N-1].valid;
    rsp_id_d    = trk_q[TRK_N-1].valid ? trk_q[TRK_N-1].id : '0;
    rsp_err_d   = trk_q[TRK_N-1].valid & trk_q[TRK_N-1].err;
    rsp_data_d  = (trk_q[TRK_N-1].valid && !trk_q[TRK_N-1].err) ? calc_out_in : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q      <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      trk_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      trk_q       <= trk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign calc_function_out = func_q;
  assign calc_dat_a_out    = a_q;
  assign calc_dat_b_out    = b_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_id            = rsp_id_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a two-register calculator model.
module tb_calc_arbiter;

  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0][1:0]      req_func = '0;
  logic [N-1:0][7:0]      req_a = '0;
  logic [N-1:0][7:0]      req_b = '0;
  logic [1:0]             calc_function_out;
  logic signed [7:0]      calc_dat_a_out, calc_dat_b_out;
  logic signed [15:0]     calc_out_in;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic signed [15:0]     rsp_data;
  logic                   rsp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int multi_grant = 0;

  always #5 clk = ~clk;

  calc_arbiter #(.NUM_REQ(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_func          (req_func),
    .req_a             (req_a),
    .req_b             (req_b),
    .calc_function_out (calc_function_out),
    .calc_dat_a_out    (calc_dat_a_out),
    .calc_dat_b_out    (calc_dat_b_out),
    .calc_out_in       (calc_out_in),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err)
  );

  // Calculator: input register, then output register.
  function automatic logic signed [15:0] calc_model(input logic [1:0] f,
                                                    input logic signed [7:0] a,
                                                    input logic signed [7:0] b);
    int ai, bi, r;
    ai = a;
    bi = b;
    case (f)
      2'b00:   r = ai + bi;
      2'b01:   r = ai - bi;
      2'b10:   r = ai * bi;
      default: r = (bi == 0) ? 0 : ai / bi;
    endcase
    return 16'(r);
  endfunction

  logic [1:0]         cm_f = '0;
  logic signed [7:0]  cm_a = '0, cm_b = '0;
  logic signed [15:0] cm_out = '0;
  always @(posedge clk) begin
    cm_f   <= calc_function_out;
    cm_a   <= calc_dat_a_out;
    cm_b   <= calc_dat_b_out;
    cm_out <= calc_model(cm_f, cm_a, cm_b);
  end
  assign calc_out_in = cm_out;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int id; } gnt_t;
  typedef struct { int cyc; int id; logic [15:0] data; logic err; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];
  logic [N-1:0] mon_x;

  always @(negedge clk) begin
    mon_x = req_valid & req_ready;
    if ($countones(mon_x) > 1) multi_grant++;
    for (int i = 0; i < N; i++) if (mon_x[i]) gq.push_back('{cyc, i});
    if (rsp_valid) rq.push_back('{cyc, int'(rsp_id), rsp_data, rsp_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b id=%0d d=%0d e=%b want all 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    checks++;
    if ({calc_function_out, calc_dat_a_out, calc_dat_b_out} !== '0) begin
      failures++;
      $display("FAIL reset_calc: got f=%b a=%0d b=%0d want all 0",
               calc_function_out, calc_dat_a_out, calc_dat_b_out);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic run_single(input string name, input int id, input logic [1:0] f,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] exp_f, input logic [7:0] exp_a,
                            input logic [7:0] exp_b, input logic [15:0] exp_d,
                            input logic exp_e);
    int t;
    bit got;
    got = 0;
    t = 0;
    rq.delete();
    req_func[id] = f;
    req_a[id]    = a;
    req_b[id]    = b;
    req_valid    = '0;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        t = cyc;
      end
      tick();
      if (got) break;
    end
    req_valid = '0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_grant: got no grant in 10 cycles want grant to %0d", name, id);
      return;
    end
    @(negedge clk);
    checks++;
    if (calc_function_out !== exp_f || calc_dat_a_out !== exp_a || calc_dat_b_out !== exp_b) begin
      failures++;
      $display("FAIL %s_issue: got f=%b a=%0d b=%0d want f=%b a=%0d b=%0d", name,
               calc_function_out, calc_dat_a_out, calc_dat_b_out,
               exp_f, $signed(exp_a), $signed(exp_b));
    end
    repeat (6) tick();
    checks++;
    if (rq.size() != 1) begin
      failures++;
      $display("FAIL %s_rsp_count: got %0d want 1", name, rq.size());
    end else begin
      checks++;
      if (rq[0].cyc != t + 4 || rq[0].id != id || rq[0].data !== exp_d || rq[0].err !== exp_e) begin
        failures++;
        $display("FAIL %s_rsp: got cyc=%0d id=%0d data=%0d err=%b want cyc=%0d id=%0d data=%0d err=%b",
                 name, rq[0].cyc, rq[0].id, $signed(rq[0].data), rq[0].err,
                 t + 4, id, $signed(exp_d), exp_e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_func[i] = 2'b00;
      req_a[i]    = 8'(i);
      req_b[i]    = 8'd10;
    end
    gq.delete();
    rq.delete();
    c0 = cyc;
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    repeat (6) tick();
    checks++;
    if (gq.size() != 8) begin
      failures++;
      $display("FAIL b2b_grant_count: got %0d want 8", gq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gq[i].cyc != c0 + i || gq[i].id != i % 4) begin
          failures++;
          $display("FAIL b2b_grant%0d: got cyc=%0d id=%0d want cyc=%0d id=%0d",
                   i, gq[i].cyc, gq[i].id, c0 + i, i % 4);
        end
      end
    end
    checks++;
    if (rq.size() != 8) begin
      failures++;
      $display("FAIL b2b_rsp_count: got %0d want 8", rq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rq[i].cyc != c0 + 4 + i || rq[i].id != i % 4 ||
            rq[i].data !== 16'(i % 4 + 10) || rq[i].err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rsp%0d: got cyc=%0d id=%0d data=%0d err=%b want cyc=%0d id=%0d data=%0d err=0",
                   i, rq[i].cyc, rq[i].id, $signed(rq[i].data), rq[i].err,
                   c0 + 4 + i, i % 4, i % 4 + 10);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int c0, k, g, n0, pre0;
    bit got;
    do_reset();
    req_func = '0;
    gq.delete();
    got = 0;
    g = 0;
    c0 = cyc;
    req_valid = 4'b0001;
    repeat (3) tick();
    k = cyc;
    req_valid[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        got = 1;
        g = cyc;
      end
      tick();
      if (got) break;
    end
    req_valid[2] = 1'b0;
    tick();
    req_valid = '0;
    repeat (6) tick();
    pre0 = 0;
    n0 = 0;
    foreach (gq[i]) begin
      if (gq[i].id == 0 && gq[i].cyc < k) pre0++;
      if (gq[i].id == 0 && gq[i].cyc >= k && gq[i].cyc < g) n0++;
    end
    checks++;
    if (pre0 != 3) begin
      failures++;
      $display("FAIL fair_solo: got %0d req0 grants before k want 3", pre0);
    end
    checks++;
    if (!got || g > k + 1) begin
      failures++;
      $display("FAIL fair_latency: got granted=%0d cyc=%0d want grant by cyc=%0d", got, g, k + 1);
    end
    checks++;
    if (n0 > 1) begin
      failures++;
      $display("FAIL fair_bypass: got %0d req0 grants in between want <=1", n0);
    end
  endtask

  task automatic test_reset_midflight();
    int c0;
    do_reset();
    gq.delete();
    rq.delete();
    c0 = cyc;
    req_func[0] = 2'b00; req_a[0] = 8'd1; req_b[0] = 8'd1;
    req_func[1] = 2'b10; req_a[1] = 8'd3; req_b[1] = 8'd4;
    req_func[2] = 2'b00; req_a[2] = 8'd2; req_b[2] = 8'd2;
    req_func[3] = 2'b00; req_a[3] = 8'd5; req_b[3] = 8'd5;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    rst = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++;
      $display("FAIL mid_ready_in_rst: got %b want 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    for (int i = 3; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, calc_function_out,
           calc_dat_a_out, calc_dat_b_out} !== '0) begin
        failures++;
        $display("FAIL mid_outputs_c%0d: got v=%b id=%0d d=%0d e=%b f=%b a=%0d b=%0d want all 0",
                 i, rsp_valid, rsp_id, rsp_data, rsp_err, calc_function_out,
                 calc_dat_a_out, calc_dat_b_out);
      end
      tick();
    end
    checks++;
    if (gq.size() != 2 || gq[0].id != 0 || gq[0].cyc != c0 || gq[1].id != 1 || gq[1].cyc != c0 + 1) begin
      failures++;
      $display("FAIL mid_accepts: got %0d grants want req0@%0d req1@%0d", gq.size(), c0, c0 + 1);
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL mid_no_rsp: got %0d responses want 0", rq.size());
    end
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_ptr_restart: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (6) tick();
  endtask

  task automatic test_onehot();
    checks++;
    if (multi_grant !== 0) begin
      failures++;
      $display("FAIL onehot: got %0d multi-grant cycles want 0", multi_grant);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    run_single("add",   1, 2'b00, 8'd5,    8'(-3),  2'b00, 8'd5,    8'(-3),  16'd2,      1'b0);
    run_single("mul",   0, 2'b10, 8'h80,   8'h80,   2'b10, 8'h80,   8'h80,   16'd16384,  1'b0);
    run_single("sub",   3, 2'b01, 8'h80,   8'd127,  2'b01, 8'h80,   8'd127,  16'(-255),  1'b0);
    run_single("div",   1, 2'b11, 8'(-7),  8'd2,    2'b11, 8'(-7),  8'd2,    16'(-3),    1'b0);
    run_single("divz",  2, 2'b11, 8'd7,    8'd0,    2'b00, 8'd0,    8'd0,    16'd0,      1'b1);
    test_back_to_back();
    test_fairness();
    test_reset_midflight();
    test_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
